output_serializer: RTL and testbench

//   Downstream consumer of the 256-bit output register. Captures a snapshot of the

---
 rtl/output_serializer.sv | 108 ++++++++++
 tb/tb_output_serializer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/output_serializer.sv
// Snapshot-and-stream serializer: captures a DataW-bit value on load and emits it
// as OutW-bit words over valid/ready, least-significant word first.
module output_serializer #(
  parameter int unsigned DataW = 256,
  parameter int unsigned OutW  = 16,
  localparam int unsigned NumW = DataW / OutW,
  localparam int unsigned IdxW = (NumW > 1) ? $clog2(NumW) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [DataW-1:0] load_data_i,
  input  logic             out_ready_i,
  input  logic             overrun_clr_i,
  output logic             out_valid_o,
  output logic [OutW-1:0]  out_data_o,
  output logic [IdxW-1:0]  out_index_o,
  output logic             out_last_o,
  output logic             busy_o,
  output logic             overrun_o
);

  typedef enum logic {StIdle, StSend} state_e;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumW - 1);

  state_e            state_q, state_d;
  logic [DataW-1:0]  buf_q, buf_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [OutW-1:0]   data_q, data_d;
  logic              last_q, last_d;
  logic              overrun_q, overrun_d;
  logic              xfer, frame_done;

  assign xfer       = (state_q == StSend) && out_ready_i;
  assign frame_done = xfer && (idx_q == LastIdx);

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;

    if (overrun_clr_i) begin
      overrun_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (load_i) begin
          buf_d   = load_data_i;
          idx_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (frame_done) begin
          idx_d = '0;
          // A load on the final-word edge starts the next frame with no bubble.
          if (load_i) begin
            buf_d = load_data_i;
          end else begin
            state_d = StIdle;
          end
        end else begin
          if (xfer) begin
            idx_d = idx_q + IdxW'(1);
          end
          // Set after the clear so a simultaneous set wins.
          if (load_i) begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Word outputs are registered: precompute what the next cycle presents.
    data_d = buf_d[idx_d*OutW +: OutW];
    last_d = (state_d == StSend) && (idx_d == LastIdx);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      buf_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid_o = (state_q == StSend);
  assign busy_o      = (state_q == StSend);
  assign out_data_o  = data_q;
  assign out_index_o = idx_q;
  assign out_last_o  = last_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_output_serializer.sv
// Bench for output_serializer: frame-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_output_serializer;

  localparam int unsigned DataW = 256;
  localparam int unsigned OutW  = 16;
  localparam int unsigned NumW  = DataW / OutW;
  localparam int unsigned IdxW  = 4;

  localparam logic [DataW-1:0] FrameK =
    256'h000F000E000D000C000B000A0009000800070006000500040003000200010000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load;
  logic [DataW-1:0] load_data;
  logic             out_ready;
  logic             overrun_clr;
  logic             out_valid;
  logic [OutW-1:0]  out_data;
  logic [IdxW-1:0]  out_index;
  logic             out_last;
  logic             busy;
  logic             overrun;

  int checks = 0;
  int errors = 0;

  output_serializer #(.DataW(DataW), .OutW(OutW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .load_i       (load),
    .load_data_i  (load_data),
    .out_ready_i  (out_ready),
    .overrun_clr_i(overrun_clr),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .out_index_o  (out_index),
    .out_last_o   (out_last),
    .busy_o       (busy),
    .overrun_o    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DataW-1:0] act,
                     input logic [DataW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame being sent, which word is on the port, and the
  // sequence of words actually handed to the sink.
  logic [DataW-1:0] m_frame  = '0;
  int               m_word   = 0;
  bit               m_active = 1'b0;
  bit               m_ovr    = 1'b0;
  bit               m_loaded = 1'b0;
  logic [OutW-1:0]  sent_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_frame  = '0;
      m_word   = 0;
      m_active = 1'b0;
      m_ovr    = 1'b0;
      m_loaded = 1'b0;
    end else begin
      bit taken, done, can_take;
      taken    = m_active && out_ready;
      done     = taken && (m_word == NumW - 1);
      can_take = !m_active || done;
      if (taken) sent_q.push_back(m_frame[m_word*OutW +: OutW]);
      if (load && !can_take) m_ovr = 1'b1;
      else if (overrun_clr) m_ovr = 1'b0;
      if (load && can_take) begin
        m_frame  = load_data;
        m_word   = 0;
        m_active = 1'b1;
        m_loaded = 1'b1;
      end else if (done) begin
        m_active = 1'b0;
        m_word   = 0;
      end else if (taken) begin
        m_word++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", out_valid, m_active);
      chk("busy", busy, m_active);
      chk("overrun", overrun, m_ovr);
      if (m_active) begin
        chk("data", out_data, m_frame[m_word*OutW +: OutW]);
        chk("index", out_index, m_word);
        chk("last", out_last, m_word == NumW - 1);
      end else begin
        chk("last_idle", out_last, 1'b0);
        if (!m_loaded) chk("data_idle", out_data, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start_frame(input logic [DataW-1:0] d);
    load      = 1'b1;
    load_data = d;
    step();
    load      = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    if (busy) chk({name, "_timeout"}, 1'b1, 1'b0);
  endtask

  task automatic run_to_index(input string name, input int idx);
    int n = 0;
    while (!(busy && out_index == idx) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk({name, "_timeout"}, 1'b1, 1'b0);
  endtask

  task automatic chk_sent_k(input string name);
    chk({name, "_count"}, sent_q.size(), NumW);
    for (int k = 0; k < sent_q.size(); k++) chk({name, "_word"}, sent_q[k], k);
  endtask

  logic [DataW-1:0] frame_a, frame_b, frame_c;

  initial begin
    for (int k = 0; k < NumW; k++) begin
      frame_a[k*OutW +: OutW] = 16'hAAAA;
      frame_b[k*OutW +: OutW] = 16'h5555;
      frame_c[k*OutW +: OutW] = 16'h1234;
    end
    rst_n       = 1'b0;
    load        = 1'b0;
    load_data   = '0;
    out_ready   = 1'b0;
    overrun_clr = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // 1: idle after reset
    repeat (10) step();
    chk("t1_valid", out_valid, 1'b0);
    chk("t1_data", out_data, 0);

    // 2: straight frame, ready held high
    out_ready = 1'b1;
    sent_q.delete();
    start_frame(FrameK);
    chk("t2_first_valid", out_valid, 1'b1);
    chk("t2_first_data", out_data, 16'h0000);
    drain("t2");
    chk_sent_k("t2");
    chk("t2_busy_end", busy, 1'b0);

    // 3: ready toggling 1,0,1,0 -> 31 valid cycles
    begin
      int n = 0;
      sent_q.delete();
      start_frame(FrameK);
      while (busy && n < 80) begin
        out_ready = (n % 2 == 0);
        step();
        n++;
      end
      chk("t3_cycles", n, 31);
      chk_sent_k("t3");
    end

    // 4: back-to-back frame on the final-word edge
    out_ready = 1'b1;
    start_frame(frame_a);
    run_to_index("t4", 15);
    chk("t4_last", out_last, 1'b1);
    start_frame(frame_b);
    chk("t4_b_valid", out_valid, 1'b1);
    chk("t4_b_data", out_data, 16'h5555);
    chk("t4_b_index", out_index, 0);
    chk("t4_overrun", overrun, 1'b0);
    drain("t4");

    // 5: load mid-frame is dropped and flagged
    sent_q.delete();
    start_frame(FrameK);
    run_to_index("t5", 3);
    start_frame(frame_c);
    chk("t5_overrun", overrun, 1'b1);
    chk("t5_data", out_data, 16'h0004);
    drain("t5");
    chk_sent_k("t5");
    chk("t5_sticky", overrun, 1'b1);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    chk("t5_cleared", overrun, 1'b0);

    // 6: asynchronous reset mid-frame
    start_frame(FrameK);
    run_to_index("t6", 7);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", out_valid, 1'b0);
    chk("t6_data", out_data, 0);
    chk("t6_index", out_index, 0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_last", out_last, 1'b0);
    step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("t6_quiet", out_valid, 1'b0);
    sent_q.delete();
    start_frame(FrameK);
    drain("t6");
    chk_sent_k("t6");

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
